// File: rtl/fifo_burst_reader.sv
// Burst reader for a 1-cycle-latency FIFO read port.
// Fetches len words per start and streams them out on valid/ready.
module fifo_burst_reader #(
    parameter int DW   = 8,
    parameter int LENW = 8,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [LENW-1:0] len,
    output logic            busy,
    output logic            done,
    input  logic            fifo_empty,
    output logic            fifo_pop,
    input  logic [DW-1:0]   fifo_data,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [DW-1:0]   m_data,
    output logic [CNTW-1:0] words_total
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t          state;
    logic [LENW-1:0] issue_left;
    logic [LENW-1:0] deliver_left;
    logic            inflight;
    logic [1:0]      buf_count;
    logic [DW-1:0]   buf0;
    logic [DW-1:0]   buf1;
    logic [1:0]      occupancy;
    logic            hs;
    logic            credit_ok;

    assign m_valid   = (buf_count != 2'd0);
    assign m_data    = buf0;
    assign hs        = m_valid && m_ready;
    assign occupancy = {1'b0, inflight} + buf_count;
    // A beat leaving this cycle frees a slot, keeping one word per cycle
    assign credit_ok = hs ? (occupancy < 2'd3) : (occupancy < 2'd2);
    assign fifo_pop  = (state == READ) && !fifo_empty &&
                       (issue_left != '0) && credit_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            issue_left   <= '0;
            deliver_left <= '0;
            inflight     <= 1'b0;
            buf_count    <= 2'd0;
            buf0         <= '0;
            buf1         <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            words_total  <= '0;
        end else begin
            done     <= 1'b0;
            inflight <= fifo_pop;

            if (inflight && !hs) begin
                if (buf_count == 2'd0) buf0 <= fifo_data;
                else                   buf1 <= fifo_data;
                buf_count <= buf_count + 2'd1;
            end else if (!inflight && hs) begin
                buf0      <= buf1;
                buf_count <= buf_count - 2'd1;
            end else if (inflight && hs) begin
                if (buf_count == 2'd1) begin
                    buf0 <= fifo_data;
                end else begin
                    buf0 <= buf1;
                    buf1 <= fifo_data;
                end
            end

            if (hs) begin
                if (deliver_left != '0) deliver_left <= deliver_left - 1'b1;
                if (words_total != '1) words_total <= words_total + 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            issue_left   <= len;
                            deliver_left <= len;
                            busy         <= 1'b1;
                            state        <= READ;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (fifo_pop) begin
                        issue_left <= issue_left - 1'b1;
                        if (issue_left == 1) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (deliver_left == '0 || (hs && deliver_left == 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
